// File: rtl/gpi_bank_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpi_bank_conditioner
// Brief    : NCH-channel GPI input conditioner. Each channel gates its pad
//            input with the input enable and synchronises it. A glitch filter
//            then debounces the level, and the block produces a clean level
//            plus registered rise/fall strobes. The optional sticky
//            edge-interrupt pending bits are built only when GPI_BANK_IRQ_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gpi_bank_conditioner #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic [NCH-1:0]   PAD_DI_I,
  input  logic [NCH-1:0]   IE_I,
  input  logic [CNT_W-1:0] DEB_LIM_I,
`ifdef GPI_BANK_IRQ_EN
  input  logic [NCH-1:0]   IRQ_RISE_EN_I,
  input  logic [NCH-1:0]   IRQ_FALL_EN_I,
  input  logic [NCH-1:0]   IRQ_CLR_I,
  output logic [NCH-1:0]   IRQ_PEND_O,
  output logic             IRQ_O,
`endif
  output logic [NCH-1:0]   DI_O,
  output logic [NCH-1:0]   RISE_O,
  output logic [NCH-1:0]   FALL_O
);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  // A limit of 0 behaves as 1, so the commit threshold saturates at 0.
  logic [CNT_W-1:0] w_lim_m1;
  assign w_lim_m1 = (DEB_LIM_I == '0) ? '0 : (DEB_LIM_I - CNT_W'(1));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_cnt_eff;
    logic                   r_di;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_di_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;

    // Gate with the input enable before crossing into the CLK_I domain.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], PAD_DI_I[i] & IE_I[i]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
    // The count is only meaningful while a mismatch is being checked.
    assign w_cnt_eff = (r_state == ST_CHECK) ? r_cnt : '0;

    // Debounce decision: commit once the mismatch has lasted the limit.
    always_comb begin
      w_state_nxt = ST_STABLE;
      w_cnt_nxt   = '0;
      w_di_nxt    = r_di;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (w_s != r_di) begin
        if (w_cnt_eff >= w_lim_m1) begin
          w_di_nxt   = w_s;
          w_rise_nxt = w_s;
          w_fall_nxt = ~w_s;
        end else begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = w_cnt_eff + CNT_W'(1);
        end
      end
    end

    // Filter state, clean level and one-cycle edge strobes.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_di    <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_di    <= w_di_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    assign DI_O[i]   = r_di;
    assign RISE_O[i] = r_rise;
    assign FALL_O[i] = r_fall;

`ifdef GPI_BANK_IRQ_EN
    logic r_pend;

    // Sticky pending bit; a new enabled edge outranks a same-cycle clear.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= (r_pend & ~IRQ_CLR_I[i])
                | (r_rise & IRQ_RISE_EN_I[i])
                | (r_fall & IRQ_FALL_EN_I[i]);
      end
    end

    assign IRQ_PEND_O[i] = r_pend;
`endif
  end

`ifdef GPI_BANK_IRQ_EN
  assign IRQ_O = |IRQ_PEND_O;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpi_bank_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpi_bank_conditioner
// Brief    : Self-checking bench for gpi_bank_conditioner. It combines a
//            directed vector table, hand-written multi-cycle sequences and
//            randomised traffic. The traffic is compared against a
//            run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpi_bank_conditioner;

  localparam int NCH  = 8;
  localparam int SYNC = 2;

  logic           CLK_I = 1'b0;
  logic           RSTN_I;
  logic [NCH-1:0] PAD_DI_I;
  logic [NCH-1:0] IE_I;
  logic [7:0]     DEB_LIM_I;
  logic [NCH-1:0] DI_O, RISE_O, FALL_O;
`ifdef GPI_BANK_IRQ_EN
  logic [NCH-1:0] IRQ_RISE_EN_I, IRQ_FALL_EN_I, IRQ_CLR_I, IRQ_PEND_O;
  logic           IRQ_O;
`endif

  gpi_bank_conditioner #(.NCH(NCH), .SYNC_STAGES(SYNC), .CNT_W(8)) u_dut (
    .CLK_I         (CLK_I),
    .RSTN_I        (RSTN_I),
    .PAD_DI_I      (PAD_DI_I),
    .IE_I          (IE_I),
    .DEB_LIM_I     (DEB_LIM_I),
`ifdef GPI_BANK_IRQ_EN
    .IRQ_RISE_EN_I (IRQ_RISE_EN_I),
    .IRQ_FALL_EN_I (IRQ_FALL_EN_I),
    .IRQ_CLR_I     (IRQ_CLR_I),
    .IRQ_PEND_O    (IRQ_PEND_O),
    .IRQ_O         (IRQ_O),
`endif
    .DI_O          (DI_O),
    .RISE_O        (RISE_O),
    .FALL_O        (FALL_O)
  );

  always #5 CLK_I = ~CLK_I;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a channel commits once the synchronised level has
  // disagreed with the output for max(limit,1) consecutive edges.
  bit [SYNC-1:0]  m_pipe [NCH];
  int             m_run  [NCH];
  logic [NCH-1:0] m_di, m_rise, m_fall, m_pend;

  typedef struct {
    logic [7:0] pad;
    logic [7:0] lim;
    logic [7:0] di;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_pipe[c] = '0;
      m_run[c]  = 0;
    end
    m_di = '0; m_rise = '0; m_fall = '0; m_pend = '0;
  endtask

  task automatic model_step();
    int lim;
    lim = (DEB_LIM_I == 8'd0) ? 1 : int'(DEB_LIM_I);
    for (int c = 0; c < NCH; c++) begin
      bit s;
      s = m_pipe[c][SYNC-1];
`ifdef GPI_BANK_IRQ_EN
      m_pend[c] = (m_pend[c] & ~IRQ_CLR_I[c]) | (m_rise[c] & IRQ_RISE_EN_I[c])
                | (m_fall[c] & IRQ_FALL_EN_I[c]);
`endif
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (s != m_di[c]) begin
        m_run[c]++;
        if (m_run[c] >= lim) begin
          m_di[c]   = s;
          m_rise[c] = s;
          m_fall[c] = !s;
          m_run[c]  = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      for (int k = SYNC-1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
      m_pipe[c][0] = PAD_DI_I[c] & IE_I[c];
    end
  endtask

  // One clock edge: advance the model, then compare on the falling edge.
  task automatic tick();
    @(posedge CLK_I);
    model_step();
    @(negedge CLK_I);
    chk("DI_O", DI_O, m_di);
    chk("RISE_O", RISE_O, m_rise);
    chk("FALL_O", FALL_O, m_fall);
    chk("RISE&FALL", RISE_O & FALL_O, 0);
`ifdef GPI_BANK_IRQ_EN
    chk("IRQ_PEND_O", IRQ_PEND_O, m_pend);
    chk("IRQ_O", IRQ_O, |m_pend);
`endif
  endtask

  function automatic void addv(input logic [7:0] pad, input logic [7:0] lim,
                               input logic [7:0] di, input logic [7:0] rise,
                               input logic [7:0] fall);
    vec_t v;
    v.pad = pad; v.lim = lim; v.di = di; v.rise = rise; v.fall = fall;
    tbl.push_back(v);
  endfunction

  initial begin
    bit found;

    // Directed table: ch0 bypass filter, then ch1 glitch / long pulse at limit 4.
    for (int j = 0; j < 2; j++) addv(8'h01, 8'd0, 8'h00, 8'h00, 8'h00);
    addv(8'h01, 8'd0, 8'h01, 8'h01, 8'h00);
    addv(8'h01, 8'd0, 8'h01, 8'h00, 8'h00);
    for (int j = 0; j < 2; j++) addv(8'h00, 8'd0, 8'h01, 8'h00, 8'h00);
    addv(8'h00, 8'd0, 8'h00, 8'h00, 8'h01);
    addv(8'h00, 8'd0, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < 3; j++) addv(8'h02, 8'd4, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < 5; j++) addv(8'h00, 8'd4, 8'h00, 8'h00, 8'h00);
    for (int j = 0; j < 5; j++) addv(8'h02, 8'd4, 8'h00, 8'h00, 8'h00);
    addv(8'h02, 8'd4, 8'h02, 8'h02, 8'h00);
    for (int j = 0; j < 5; j++) addv(8'h00, 8'd4, 8'h02, 8'h00, 8'h00);
    addv(8'h00, 8'd4, 8'h00, 8'h00, 8'h02);
    addv(8'h00, 8'd4, 8'h00, 8'h00, 8'h00);

    RSTN_I = 1'b0; PAD_DI_I = '0; IE_I = '1; DEB_LIM_I = 8'd0;
`ifdef GPI_BANK_IRQ_EN
    IRQ_RISE_EN_I = '0; IRQ_FALL_EN_I = '0; IRQ_CLR_I = '0;
`endif
    model_reset();
    repeat (2) @(posedge CLK_I);
    #1;
    chk("reset DI_O", DI_O, 0);
    chk("reset RISE_O", RISE_O, 0);
    chk("reset FALL_O", FALL_O, 0);
`ifdef GPI_BANK_IRQ_EN
    chk("reset IRQ_PEND_O", IRQ_PEND_O, 0);
`endif
    @(negedge CLK_I);
    RSTN_I = 1'b1;

    foreach (tbl[n]) begin
      PAD_DI_I  = tbl[n].pad;
      DEB_LIM_I = tbl[n].lim;
      tick();
      chk($sformatf("tbl[%0d] DI_O", n), DI_O, tbl[n].di);
      chk($sformatf("tbl[%0d] RISE_O", n), RISE_O, tbl[n].rise);
      chk($sformatf("tbl[%0d] FALL_O", n), FALL_O, tbl[n].fall);
    end

    // Input-enable drop on a high channel produces exactly one fall.
    DEB_LIM_I = 8'd2; PAD_DI_I = 8'h04;
    repeat (6) tick();
    chk("ie ch2 high", DI_O[2], 1);
    IE_I = 8'hFB;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("ie ch2 hold", {DI_O[2], FALL_O[2]}, 2'b10);
    end
    tick();
    chk("ie ch2 fall", {DI_O[2], FALL_O[2]}, 2'b01);
    for (int j = 0; j < 10; j++) begin
      PAD_DI_I[2] = ~PAD_DI_I[2];
      tick();
      chk("ie ch2 ignored", {DI_O[2], RISE_O[2]}, 2'b00);
    end

    // Reset in the middle of a long debounce discards the count.
    IE_I = '1; DEB_LIM_I = 8'd1; PAD_DI_I = 8'h01;
    repeat (5) tick();
    chk("pre-reset ch0", DI_O[0], 1);
    DEB_LIM_I = 8'd200; PAD_DI_I = 8'h21;
    repeat (102) tick();
    chk("mid-count ch5", DI_O[5], 0);
    #2 RSTN_I = 1'b0;
    #1;
    chk("async reset DI_O", DI_O, 0);
    chk("async reset strobes", {RISE_O, FALL_O}, 0);
    model_reset();
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    RSTN_I = 1'b1;
    repeat (201) tick();
    chk("post-reset not yet", DI_O, 8'h00);
    tick();
    chk("post-reset commit DI_O", DI_O, 8'h21);
    chk("post-reset commit RISE_O", RISE_O, 8'h21);

`ifdef GPI_BANK_IRQ_EN
    // Sticky pending bit: set, set-beats-clear, lone clear.
    DEB_LIM_I = 8'd1; PAD_DI_I = 8'h00; IRQ_RISE_EN_I = 8'h08;
    repeat (5) tick();
    PAD_DI_I[3] = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin tick(); if (RISE_O[3]) found = 1'b1; end
    chk("ch3 rise seen", found, 1);
    tick();
    chk("irq pend3 set", {IRQ_PEND_O[3], IRQ_O}, 2'b11);
    PAD_DI_I[3] = 1'b0;
    repeat (5) tick();
    chk("irq pend3 after fall", IRQ_PEND_O[3], 1);
    PAD_DI_I[3] = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin tick(); if (RISE_O[3]) found = 1'b1; end
    chk("ch3 second rise seen", found, 1);
    IRQ_CLR_I = 8'h08;
    tick();
    IRQ_CLR_I = 8'h00;
    chk("irq set wins", IRQ_PEND_O[3], 1);
    tick();
    IRQ_CLR_I = 8'h08;
    tick();
    IRQ_CLR_I = 8'h00;
    chk("irq lone clear", {IRQ_PEND_O[3], IRQ_O}, 2'b00);
`else
    found = 1'b0;
`endif

    // Randomised traffic on all channels against the model.
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(49) == 0) DEB_LIM_I = 8'($urandom_range(5));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0) PAD_DI_I[c] = ~PAD_DI_I[c];
        if ($urandom_range(99) == 0) IE_I[c] = ~IE_I[c];
      end
`ifdef GPI_BANK_IRQ_EN
      if ($urandom_range(99) == 0) IRQ_RISE_EN_I = 8'($urandom);
      if ($urandom_range(99) == 0) IRQ_FALL_EN_I = 8'($urandom);
      IRQ_CLR_I = ($urandom_range(9) == 0) ? 8'($urandom) : 8'h00;
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
